pipe_ctrl: RTL

//  Central pipeline sequencer for the 5-stage core. Merges stall requests from ID/EX/MEM

---
 rtl/pipe_ctrl_pkg.sv | 36 +++
 rtl/pipe_ctrl_wdog.sv | 32 +++
 rtl/pipe_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and types for the pipeline sequencer.
//   Stall-vector encodings (bit0 PC .. bit5 WB, 1 = stop), reset level,
//   bus width, FSM state encoding, and the merged stall-request struct.
package pipe_ctrl_pkg;

  localparam logic STOP      = 1'b1;
  localparam logic NOSTOP    = 1'b0;
  localparam logic RSTENABLE = 1'b0;
  localparam int   REGBUS    = 64;

  localparam logic [5:0] STALL_NONE = {6{NOSTOP}};
  localparam logic [5:0] STALL_ID   = {{3{NOSTOP}}, {3{STOP}}};
  localparam logic [5:0] STALL_EX   = {{2{NOSTOP}}, {4{STOP}}};
  localparam logic [5:0] STALL_MEM  = {NOSTOP, {5{STOP}}};

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_FLUSH = 2'd1,
    CTRL_TRAP  = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic id;
    logic ex;
    logic mem;
  } stall_req_t;

  // The oldest stalled stage freezes itself and everything younger.
  function automatic logic [5:0] stall_vec(input stall_req_t r);
    if (r.mem)     return STALL_MEM;
    else if (r.ex) return STALL_EX;
    else if (r.id) return STALL_ID;
    else           return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// pipe_ctrl_wdog: stall watchdog.
//   clk, rst   : clock, synchronous active-low reset
//   run        : sequencer is in RUN
//   stalled    : stall vector is non-zero this cycle
//   fire       : counter has reached WDOG_MAX while still stalled in RUN
// Counter increments per stalled RUN cycle, saturates at WDOG_MAX and
// clears whenever the pipe is not stalled or the sequencer leaves RUN.
module pipe_ctrl_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter logic [15:0] WDOG_MAX = 16'd1023
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic stalled,
  output logic fire
);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE)     cnt <= '0;
    else if (run && stalled) begin
      if (cnt != WDOG_MAX)    cnt <= cnt + 16'd1;
    end
    else                      cnt <= '0;
  end

  assign fire = run && stalled && (cnt == WDOG_MAX);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage core.
//   Merges ID/EX/MEM stall requests into the 6-bit stall vector, arbitrates
//   PC redirects (MEM trap over EX branch) and forces a trap to WDOG_VEC
//   when a stall persists for WDOG_MAX cycles.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   stallreq_{id,ex,mem}_i      stall requests
//   branch_i / branch_pc_i      EX taken branch and target
//   trap_i / trap_pc_i          MEM exception and vector
//   stall_o[5:0]                per-stage stop ([0]PC .. [5]WB)
//   flush_o                     squash younger stage registers
//   redirect_o / redirect_pc_o  PC load strobe and target (0 when idle)
//   wdog_o                      one-cycle pulse on watchdog trap
// Option: PIPE_CTRL_PERF_EN adds perf_stall_cyc_o / perf_flush_cnt_o.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int              ADDR_W   = REGBUS,
  parameter logic [15:0]     WDOG_MAX = 16'd1023,
  parameter logic [ADDR_W-1:0] WDOG_VEC = {{(ADDR_W-9){1'b0}}, 9'h100}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              stallreq_mem_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  input  logic              trap_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]       perf_stall_cyc_o,
  output logic [31:0]       perf_flush_cnt_o,
`endif
  output logic              wdog_o
);

  ctrl_state_e state, state_nxt;
  stall_req_t  req;
  logic        run, stalled, fire;

  assign req     = '{id: stallreq_id_i, ex: stallreq_ex_i, mem: stallreq_mem_i};
  assign run     = (state == CTRL_RUN);
  assign stall_o = run ? stall_vec(req) : STALL_NONE;
  assign stalled = |stall_o;

  pipe_ctrl_wdog #(.WDOG_MAX(WDOG_MAX)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .stalled (stalled),
    .fire    (fire)
  );

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) state <= CTRL_RUN;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    flush_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    wdog_o        = 1'b0;
    unique case (state)
      CTRL_RUN: begin
        // Watchdog pre-empts any redirect presented in the same cycle.
        if (fire) begin
          state_nxt = CTRL_TRAP;
        end else if (trap_i) begin
          redirect_o    = 1'b1;
          redirect_pc_o = trap_pc_i;
          flush_o       = 1'b1;
          state_nxt     = CTRL_FLUSH;
        end else if (branch_i && !stallreq_mem_i) begin
          // Under a MEM stall EX is held, so the branch re-presents later.
          redirect_o    = 1'b1;
          redirect_pc_o = branch_pc_i;
          flush_o       = 1'b1;
          state_nxt     = CTRL_FLUSH;
        end
      end
      CTRL_FLUSH: begin
        flush_o   = 1'b1;
        state_nxt = CTRL_RUN;
      end
      CTRL_TRAP: begin
        wdog_o        = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = WDOG_VEC;
        flush_o       = 1'b1;
        state_nxt     = CTRL_FLUSH;
      end
      default: state_nxt = CTRL_RUN;
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  // Every redirect_o strobe is one accepted redirect (RUN accept or TRAP).
  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      perf_stall_cyc_o <= '0;
      perf_flush_cnt_o <= '0;
    end else begin
      if (stalled)    perf_stall_cyc_o <= perf_stall_cyc_o + 32'd1;
      if (redirect_o) perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule
